// File: rtl/ram_dma.sv
// ram_dma: word-by-word RAM-to-RAM copy engine (RD/WR ping-pong over one async-read RAM port).
// Optional FILL_EN macro adds a fill mode that writes a constant instead of copying.
module ram_dma #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
`ifdef FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
`ifdef FILL_EN
    logic              fill_q, fill_d;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
`ifdef FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
`ifdef FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
`ifdef FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                src_d   = src_addr;
                dst_d   = dst_addr;
                cnt_d   = length;
                state_d = (length == '0) ? FIN : RD;
`ifdef FILL_EN
                fill_d  = fill_mode;
                if (fill_mode) begin
                    buf_d   = fill_value;
                    state_d = (length == '0) ? FIN : WR;
                end
`endif
            end
            RD: begin
                buf_d   = mem_out;
                src_d   = src_q + ADDR_W'(1);
                state_d = WR;
            end
            WR: begin
                dst_d   = dst_q + ADDR_W'(1);
                cnt_d   = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? FIN : RD;
`ifdef FILL_EN
                if (fill_q && cnt_q != CNT_ONE) state_d = WR;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // Write enable is gated by reset so the edge that aborts a transfer never commits a word.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign mem_load    = (state_q == WR) && reset_n;
    assign mem_address = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
    assign mem_in      = (state_q == WR) ? buf_q : '0;
endmodule
